// File: rtl/seq_game_engine.sv
// Sequence mini-game engine: the player reproduces a runtime-loaded pattern on in_vec, one held
// chord per step, with a per-step tick timeout, a miss budget and suspend/resume.
module seq_game_engine #(
  parameter int IN_W       = 16,
  parameter int MAX_STEPS  = 8,
  parameter int HOLD_CYC   = 4,
  parameter int STEP_TICKS = 10,
  parameter int MAX_MISS   = 3,
  localparam int AW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1,
  localparam int MW = $clog2(MAX_MISS + 1)
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            pat_we,
  input  logic [AW-1:0]   pat_addr,
  input  logic [IN_W-1:0] pat_data,
  input  logic [AW:0]     seq_len,
  input  logic            start,
  input  logic            suspend,
  input  logic            tick,
  input  logic            ack,
  input  logic [IN_W-1:0] in_vec,
  output logic            busy,
  output logic [AW-1:0]   step_idx,
  output logic [MW-1:0]   miss_cnt,
  output logic            done,
  output logic            fail,
  output logic            step_ok,
  output logic            miss,
  output logic [2:0]      state_dbg
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int TW = $clog2(STEP_TICKS + 1);
  localparam logic [AW:0]   MAX_LEN   = (AW + 1)'(MAX_STEPS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);
  localparam logic [MW-1:0] MISS_MAX  = MW'(MAX_MISS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RELEASE = 3'd1,
    S_MATCH   = 3'd2,
    S_PAUSE   = 3'd3,
    S_DONE    = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  state_t          state;
  logic [IN_W-1:0] ram [MAX_STEPS];
  logic [AW:0]     len;
  logic [HW-1:0]   hold;
  logic [TW-1:0]   timer;

  logic [IN_W-1:0] pat;
  logic            in_zero, in_match, in_bad;
  logic            timeout, accept, last_step, start_ok, do_miss;
  logic [MW-1:0]   miss_next;

  assign state_dbg = state;
  assign pat       = ram[step_idx];
  assign in_zero   = (in_vec == '0);
  assign in_match  = (in_vec == pat);
  assign in_bad    = ((in_vec & ~pat) != '0);
  assign timeout   = tick && (timer == TICK_LAST);
  assign accept    = (state == S_MATCH) && in_match && (hold == HOLD_LAST);
  assign last_step = ({1'b0, step_idx} == (len - 1'b1));
  assign start_ok  = start && (seq_len != '0) && (seq_len <= MAX_LEN);
  assign do_miss   = ((state == S_MATCH) && in_bad) || timeout;
  assign miss_next = miss_cnt + 1'b1;

  // Pattern store has no reset so a loaded pattern survives a system reset.
  always_ff @(posedge Clk) begin
    if (state == S_IDLE && pat_we) ram[pat_addr] <= pat_data;
  end

  // Control protocol: start is sampled only in IDLE; done/fail are levels held until ack.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      len      <= '0;
      hold     <= '0;
      timer    <= '0;
      step_idx <= '0;
      miss_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      step_ok  <= 1'b0;
      miss     <= 1'b0;
    end else begin
      step_ok <= 1'b0;
      miss    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            len      <= seq_len;
            step_idx <= '0;
            miss_cnt <= '0;
            timer    <= '0;
            hold     <= '0;
            busy     <= 1'b1;
            state    <= S_RELEASE;
          end
        end
        S_RELEASE, S_MATCH: begin
          if (suspend) begin
            hold  <= '0;
            state <= S_PAUSE;
          end else if (accept) begin
            step_ok <= 1'b1;
            hold    <= '0;
            if (last_step) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              step_idx <= step_idx + 1'b1;
              timer    <= '0;
              state    <= S_RELEASE;
            end
          end else if (do_miss) begin
            // A bad chord and a timeout on the same cycle collapse into one miss.
            miss     <= 1'b1;
            miss_cnt <= miss_next;
            hold     <= '0;
            if (miss_next == MISS_MAX) begin
              busy  <= 1'b0;
              fail  <= 1'b1;
              state <= S_FAIL;
            end else begin
              step_idx <= '0;
              timer    <= '0;
              state    <= S_RELEASE;
            end
          end else begin
            if (tick) timer <= timer + 1'b1;
            if (state == S_RELEASE) begin
              if (in_zero) begin
                hold  <= '0;
                state <= S_MATCH;
              end
            end else begin
              // Partial chords and released inputs just restart the hold window.
              hold <= in_match ? hold + 1'b1 : '0;
            end
          end
        end
        S_PAUSE: begin
          if (!suspend) state <= S_RELEASE;
        end
        S_DONE: begin
          if (ack) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_FAIL: begin
          if (ack) begin
            fail  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_game_engine.sv
// Directed bench for seq_game_engine: full game, misses, partial chords, hold restart,
// timeouts to FAIL, suspend/resume, illegal start, write protection and reset retention.
module tb_seq_game_engine;

  localparam int IN_W = 16;
  localparam int AW   = 3;
  localparam int MW   = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RELEASE = 3'd1;
  localparam logic [2:0] ST_MATCH   = 3'd2;
  localparam logic [2:0] ST_PAUSE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_FAIL    = 3'd5;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            pat_we = 1'b0;
  logic [AW-1:0]   pat_addr = '0;
  logic [IN_W-1:0] pat_data = '0;
  logic [AW:0]     seq_len = '0;
  logic            start = 1'b0;
  logic            suspend = 1'b0;
  logic            tick = 1'b0;
  logic            ack = 1'b0;
  logic [IN_W-1:0] in_vec = '0;
  logic            busy, done, fail, step_ok, miss;
  logic [AW-1:0]   step_idx;
  logic [MW-1:0]   miss_cnt;
  logic [2:0]      state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  seq_game_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
    .seq_len(seq_len), .start(start), .suspend(suspend), .tick(tick), .ack(ack),
    .in_vec(in_vec), .busy(busy), .step_idx(step_idx), .miss_cnt(miss_cnt), .done(done),
    .fail(fail), .step_ok(step_ok), .miss(miss), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 Clk = ~Clk;

  // Driver tasks: inputs change 1 time unit after a rising edge, outputs sampled there too.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [IN_W-1:0] d);
    pat_we = 1'b1; pat_addr = a; pat_data = d;
    step();
    pat_we = 1'b0;
  endtask

  task automatic do_start(input logic [AW:0] len);
    seq_len = len; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic play_step(input logic [IN_W-1:0] v, input string tag);
    in_vec = '0;
    step();
    chk({tag, "_in_match"}, state_dbg, ST_MATCH);
    in_vec = v;
    repeat (3) begin
      step();
      chk({tag, "_no_early_ok"}, step_ok, 1'b0);
    end
    step();
    chk({tag, "_step_ok"}, step_ok, 1'b1);
    in_vec = '0;
  endtask

  task automatic tick_once(output logic m);
    tick = 1'b1;
    step();
    m = miss;
    tick = 1'b0;
    step();
  endtask

  logic m;
  int   ok_pulses;
  int   miss_seen;

  initial begin
    // Reset state
    step(); step();
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fail", fail, 1'b0);
    chk("rst_step_idx", step_idx, 3'd0);
    chk("rst_miss_cnt", miss_cnt, 2'd0);
    chk("rst_pulses", {step_ok, miss}, 2'b00);
    Reset_n = 1'b1;
    step();

    // Scenario 1: clean three-step game
    load(3'd0, 16'h0001);
    load(3'd1, 16'h0003);
    load(3'd2, 16'h0007);
    do_start(4'd3);
    chk("s1_busy", busy, 1'b1);
    chk("s1_state_release", state_dbg, ST_RELEASE);
    play_step(16'h0001, "s1_st0");
    chk("s1_idx1", step_idx, 3'd1);
    play_step(16'h0003, "s1_st1");
    chk("s1_idx2", step_idx, 3'd2);
    play_step(16'h0007, "s1_st2");
    chk("s1_done", done, 1'b1);
    chk("s1_busy_off", busy, 1'b0);
    chk("s1_miss_cnt", miss_cnt, 2'd0);
    chk("s1_idx_kept", step_idx, 3'd2);
    ack = 1'b1; step(); ack = 1'b0;
    chk("s1_ack_idle", state_dbg, ST_IDLE);
    chk("s1_ack_done", done, 1'b0);
    chk("s1_ack_busy", busy, 1'b0);

    // Scenario 2: bad chord is a miss, partial chord is not
    do_start(4'd3);
    in_vec = '0; step();
    in_vec = 16'h0002; step();
    chk("s2_miss_pulse", miss, 1'b1);
    chk("s2_miss_cnt", miss_cnt, 2'd1);
    chk("s2_idx0", step_idx, 3'd0);
    chk("s2_restart", state_dbg, ST_RELEASE);
    play_step(16'h0001, "s2_st0");
    in_vec = '0; step();
    in_vec = 16'h0001;
    repeat (2) begin
      step();
      chk("s2_partial_no_miss", miss, 1'b0);
    end
    in_vec = 16'h0003;
    repeat (3) begin
      step();
      chk("s2_partial_no_ok", step_ok, 1'b0);
    end
    step();
    chk("s2_accept", step_ok, 1'b1);
    chk("s2_miss_cnt_kept", miss_cnt, 2'd1);

    // Scenario 3: interrupted hold restarts the count
    ok_pulses = 0;
    in_vec = '0; step();
    in_vec = 16'h0007;
    repeat (3) begin step(); ok_pulses += int'(step_ok); end
    in_vec = '0; step(); ok_pulses += int'(step_ok);
    in_vec = 16'h0007;
    repeat (3) begin step(); ok_pulses += int'(step_ok); end
    chk("s3_no_ok_before_4th", ok_pulses, 0);
    step();
    chk("s3_ok_on_4th", step_ok, 1'b1);
    chk("s3_done", done, 1'b1);
    in_vec = '0;
    ack = 1'b1; step(); ack = 1'b0;

    // Scenario 4: timeouts, coincident timeout + bad chord, then FAIL
    do_start(4'd3);
    miss_seen = 0;
    repeat (9) begin tick_once(m); miss_seen += int'(m); end
    chk("s4_no_early_timeout", miss_seen, 0);
    tick_once(m);
    chk("s4_timeout1", m, 1'b1);
    chk("s4_cnt1", miss_cnt, 2'd1);
    repeat (9) tick_once(m);
    in_vec = 16'h0002;
    tick_once(m);
    in_vec = '0;
    chk("s4_coincide_miss", m, 1'b1);
    chk("s4_coincide_cnt", miss_cnt, 2'd2);
    chk("s4_coincide_not_fail", fail, 1'b0);
    repeat (10) tick_once(m);
    chk("s4_timeout3", m, 1'b1);
    chk("s4_fail", fail, 1'b1);
    chk("s4_fail_busy", busy, 1'b0);
    chk("s4_fail_cnt", miss_cnt, 2'd3);
    chk("s4_fail_state", state_dbg, ST_FAIL);
    ack = 1'b1; step(); ack = 1'b0;
    chk("s4_ack_fail", fail, 1'b0);

    // Scenario 5: suspend freezes timer and step, resume continues the timeout
    do_start(4'd3);
    play_step(16'h0001, "s5_st0");
    repeat (5) tick_once(m);
    suspend = 1'b1; step();
    chk("s5_pause", state_dbg, ST_PAUSE);
    chk("s5_pause_busy", busy, 1'b1);
    miss_seen = 0;
    repeat (20) begin tick_once(m); miss_seen += int'(m); end
    chk("s5_pause_no_miss", miss_seen, 0);
    chk("s5_pause_idx", step_idx, 3'd1);
    chk("s5_pause_cnt", miss_cnt, 2'd0);
    suspend = 1'b0; step();
    chk("s5_resume", state_dbg, ST_RELEASE);
    repeat (4) begin tick_once(m); miss_seen += int'(m); end
    chk("s5_no_miss_4", miss_seen, 0);
    tick_once(m);
    chk("s5_timeout", m, 1'b1);
    chk("s5_cnt", miss_cnt, 2'd1);
    chk("s5_idx0", step_idx, 3'd0);

    // Scenario 6: write protection, reset mid-game, illegal start, pattern retention
    in_vec = '0; step();
    chk("s6_match", state_dbg, ST_MATCH);
    load(3'd0, 16'hFFFF);
    in_vec = 16'h0001; step();
    Reset_n = 1'b0; #1;
    chk("s6_rst_state", state_dbg, ST_IDLE);
    chk("s6_rst_busy", busy, 1'b0);
    chk("s6_rst_cnt", miss_cnt, 2'd0);
    chk("s6_rst_idx", step_idx, 3'd0);
    in_vec = '0;
    step();
    Reset_n = 1'b1;
    step();
    do_start(4'd0);
    chk("s6_len0_idle", state_dbg, ST_IDLE);
    do_start(4'd9);
    chk("s6_len9_idle", state_dbg, ST_IDLE);
    chk("s6_len9_busy", busy, 1'b0);
    do_start(4'd3);
    chk("s6_rerun_busy", busy, 1'b1);
    play_step(16'h0001, "s6_st0");
    play_step(16'h0003, "s6_st1");
    play_step(16'h0007, "s6_st2");
    chk("s6_rerun_done", done, 1'b1);
    chk("s6_rerun_cnt", miss_cnt, 2'd0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("s6_final_idle", state_dbg, ST_IDLE);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
